// File: rtl/fft_input_reorder.sv
// Serial-to-parallel front end for the 16-point FFT: natural-order samples are
// written at bit-reversed addresses into a ping-pong buffer and presented as 16 lanes.
module fft_input_reorder #(
   parameter int DATA_WIDTH = 16,
   parameter int N_POINTS   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_real,
   input  logic [DATA_WIDTH-1:0]          in_imag,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [N_POINTS*DATA_WIDTH-1:0] out_real,
   output logic [N_POINTS*DATA_WIDTH-1:0] out_imag,
   output logic                           frame_error
);

   localparam int IDX_W = $clog2(N_POINTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

   logic [DATA_WIDTH-1:0] bank_real [2][N_POINTS];
   logic [DATA_WIDTH-1:0] bank_imag [2][N_POINTS];
   logic [1:0]            full;
   logic                  wr_bank;
   logic                  rd_bank;
   logic [IDX_W-1:0]      wr_idx;

   logic accept;
   logic consume;
   logic close_frame;
   logic bad_frame;

   function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] rev;
      for (int unsigned b = 0; b < IDX_W; b++) begin
         rev[b] = idx[IDX_W-1-b];
      end
      return rev;
   endfunction

   always_comb begin
      in_ready    = !full[wr_bank];
      out_valid   = full[rd_bank];
      accept      = in_valid && in_ready;
      consume     = out_valid && out_ready;
      close_frame = accept && (wr_idx == LAST_IDX) && in_last;
      bad_frame   = accept && ((wr_idx == LAST_IDX) != in_last);
   end

   // A rejected sample may land in the write bank; harmless, since that bank
   // is not full and the partial frame restarts from index 0 anyway.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned k = 0; k < N_POINTS; k++) begin
               bank_real[b][k] <= '0;
               bank_imag[b][k] <= '0;
            end
         end
      end else if (accept) begin
         bank_real[wr_bank][bitrev(wr_idx)] <= in_real;
         bank_imag[wr_bank][bitrev(wr_idx)] <= in_imag;
      end
   end

   // Close and consume always hit different banks (close needs an empty bank,
   // consume a full one), so both full-flag updates can apply together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full        <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_idx      <= '0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= bad_frame;
         if (accept) begin
            if (close_frame) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
               wr_idx        <= '0;
            end else if (bad_frame) begin
               wr_idx <= '0;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
         if (consume) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= !rd_bank;
         end
      end
   end

   for (genvar k = 0; k < N_POINTS; k++) begin : g_lane
      assign out_real[k*DATA_WIDTH +: DATA_WIDTH] = bank_real[rd_bank][k];
      assign out_imag[k*DATA_WIDTH +: DATA_WIDTH] = bank_imag[rd_bank][k];
   end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Scoreboard bench for fft_input_reorder: directed frames push expected lane
// images; a negedge monitor compares every consumed frame.
module tb_fft_input_reorder;

   localparam int W = 16;
   localparam int N = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_real;
   logic [W-1:0]   in_imag;
   logic           in_last;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] out_real;
   logic [N*W-1:0] out_imag;
   logic           frame_error;

   typedef struct {
      logic [N*W-1:0] re;
      logic [N*W-1:0] im;
   } frame_t;

   frame_t sb[$];
   int checks = 0;
   int errors = 0;

   fft_input_reorder #(.DATA_WIDTH(W), .N_POINTS(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_real(out_real), .out_imag(out_imag),
      .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (actual running, required done)");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] rev4(input logic [3:0] i);
      return {i[0], i[1], i[2], i[3]};
   endfunction

   // Lane k holds natural-order sample rev4(k).
   function automatic frame_t make_frame(input logic [W-1:0] base_re, input logic [W-1:0] base_im,
                                         input int step_re);
      frame_t f;
      for (int k = 0; k < N; k++) begin
         f.re[k*W +: W] = base_re + W'(step_re * int'(rev4(4'(k))));
         f.im[k*W +: W] = base_im + W'(k == 0 ? 0 : int'(rev4(4'(k))));
      end
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sample(input logic [W-1:0] r, input logic [W-1:0] i, input logic last);
      int wait_cnt = 0;
      in_valid = 1'b1;
      in_real  = r;
      in_imag  = i;
      in_last  = last;
      while (!in_ready && wait_cnt < 200) begin
         step();
         wait_cnt++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_wait: actual 0 required 1 within 200 cycles");
      end else begin
         step();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] base_re, input logic [W-1:0] base_im,
                             input int step_re, input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         send_sample(base_re + W'(step_re * i), base_im + W'(i), (i == last_at));
      end
   endtask

   task automatic consume_pulse();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: actual frame lane0 %0h required none", out_real[W-1:0]);
         end else begin
            frame_t exp_f;
            exp_f = sb.pop_front();
            checks++;
            if (out_real !== exp_f.re || out_imag !== exp_f.im) begin
               errors++;
               $display("FAIL sb_frame: actual re %0h im %0h required re %0h im %0h",
                        out_real, out_imag, exp_f.re, exp_f.im);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; in_last = 1'b0; out_ready = 1'b0;
      step();
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_frame_error", 64'(frame_error), 64'd0);
      chk("rst_out_real", 64'(out_real != '0), 64'd0);
      rst = 1'b0;
      step();

      // Natural-order frame: real = i, imag = 100 + i
      send_frame(16'd0, 16'd100, 1, 15, -1);
      chk("nat_latency_before", 64'(out_valid), 64'd0);
      send_sample(16'd15, 16'd115, 1'b1);
      sb.push_back(make_frame(16'd0, 16'd100, 1));
      chk("nat_out_valid", 64'(out_valid), 64'd1);
      chk("nat_lane1_real", 64'(out_real[1*W +: W]), 64'd8);
      chk("nat_lane2_real", 64'(out_real[2*W +: W]), 64'd4);
      chk("nat_lane15_real", 64'(out_real[15*W +: W]), 64'd15);
      chk("nat_lane1_imag", 64'(out_imag[1*W +: W]), 64'd108);

      // Ping-pong backpressure: frame 2 fills bank B, then input stalls
      send_frame(16'h0200, 16'h0300, 1, 16, 15);
      sb.push_back(make_frame(16'h0200, 16'h0300, 1));
      chk("pp_in_ready_low", 64'(in_ready), 64'd0);
      chk("pp_frame1_held", 64'(out_real[1*W +: W]), 64'd8);
      in_valid = 1'b1; in_real = 16'h04AA; in_imag = 16'h04AA; in_last = 1'b0;
      step();
      in_valid = 1'b0;
      chk("pp_still_stalled", 64'(in_ready), 64'd0);
      consume_pulse();
      chk("pp_in_ready_high", 64'(in_ready), 64'd1);
      chk("pp_out_valid", 64'(out_valid), 64'd1);
      chk("pp_lane0_frame2", 64'(out_real[0 +: W]), 64'h0200);

      // Simultaneous close of frame 3 and consume of frame 2
      send_frame(16'h0400, 16'h0500, 1, 15, -1);
      sb.push_back(make_frame(16'h0400, 16'h0500, 1));
      out_ready = 1'b1;
      send_sample(16'h040F, 16'h050F, 1'b1);
      out_ready = 1'b0;
      chk("sim_out_valid", 64'(out_valid), 64'd1);
      chk("sim_in_ready", 64'(in_ready), 64'd1);
      chk("sim_lane0_frame3", 64'(out_real[0 +: W]), 64'h0400);
      chk("sim_lane8_frame3", 64'(out_real[8*W +: W]), 64'h0401);
      consume_pulse();
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      // Early in_last on sample 5
      send_frame(16'h0500, 16'h0600, 1, 6, 5);
      chk("early_frame_error", 64'(frame_error), 64'd1);
      chk("early_out_valid", 64'(out_valid), 64'd0);
      step();
      chk("early_error_pulse_end", 64'(frame_error), 64'd0);
      send_frame(16'h0600, 16'h0700, 1, 16, 15);
      sb.push_back(make_frame(16'h0600, 16'h0700, 1));
      chk("early_recover_valid", 64'(out_valid), 64'd1);
      chk("early_recover_lane4", 64'(out_real[4*W +: W]), 64'h0602);
      consume_pulse();

      // Missing in_last on sample 15
      send_frame(16'h0700, 16'h0800, 1, 16, -1);
      chk("miss_frame_error", 64'(frame_error), 64'd1);
      chk("miss_out_valid", 64'(out_valid), 64'd0);
      step();
      chk("miss_error_pulse_end", 64'(frame_error), 64'd0);
      chk("miss_out_valid_after", 64'(out_valid), 64'd0);

      // Reset mid-frame with a frame presented
      send_frame(16'h0800, 16'h0900, 1, 16, 15);
      chk("rstmid_presented", 64'(out_valid), 64'd1);
      send_frame(16'h0A00, 16'h0B00, 1, 7, -1);
      #3;
      rst = 1'b1;
      #1;
      sb.delete();
      chk("rstmid_out_valid", 64'(out_valid), 64'd0);
      chk("rstmid_out_real", 64'(out_real != '0), 64'd0);
      chk("rstmid_out_imag", 64'(out_imag != '0), 64'd0);
      step();
      rst = 1'b0;
      chk("rstmid_in_ready", 64'(in_ready), 64'd1);
      send_frame(16'hFFFF, 16'h8000, -1, 16, 15);
      sb.push_back(make_frame(16'hFFFF, 16'h8000, -1));
      chk("neg_out_valid", 64'(out_valid), 64'd1);
      chk("neg_lane0_real", 64'(out_real[0 +: W]), 64'hFFFF);
      chk("neg_lane1_real", 64'(out_real[1*W +: W]), 64'hFFF7);
      chk("neg_lane15_imag", 64'(out_imag[15*W +: W]), 64'h800F);
      consume_pulse();
      step();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("end_out_valid", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
